alien_bullet_ctrl: RTL and testbench

Consumer end of the alien fire interface: accepts `alien_shoot` pulses from the alien formation logic, picks the firing alien round-robin, spawns a bullet below that alien, moves all live bullets down the screen on each frame tick and reports hits on the player. It sits between the alien formation logic and the renderer and collision and score logic.

---
 rtl/alien_bullet_ctrl.sv | 141 ++++++++++++++
 tb/tb_alien_bullet_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_bullet_ctrl.sv
// Alien bullet pool: round-robin shooter select, spawn into lowest free slot, per-tick fall and player hit test.
// Outputs registered (1-cycle latency); no backpressure, rejected requests pulse shot_dropped. Option: ALIEN_BULLET_COOLDOWN_EN.
module alien_bullet_ctrl #(
   parameter int NUM_BULLETS = 4,
   parameter int NUM_ALIENS  = 5,
   parameter int SPEED       = 4,
   parameter int SCREEN_H    = 480,
   parameter int ALIEN_W     = 16,
   parameter int ALIEN_H     = 16,
   parameter int BULLET_W    = 2,
   parameter int BULLET_H    = 6,
   parameter int PLAYER_Y    = 440,
   parameter int PLAYER_W    = 24,
   parameter int PLAYER_H    = 12,
   parameter int COOLDOWN    = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     tick,
   input  logic                     alien_shoot,
   input  logic [9:0]               shooter_x,
   input  logic [8:0]               shooter_y,
   input  logic [9:0]               player_x,
   output logic [2:0]               shooter_sel,
   output logic [NUM_BULLETS-1:0]   bullet_active,
   output logic [NUM_BULLETS*10-1:0] bullet_x,
   output logic [NUM_BULLETS*10-1:0] bullet_y,
   output logic                     player_hit,
   output logic                     shot_dropped
);

   if (NUM_BULLETS < 2 || NUM_BULLETS > 8 || NUM_ALIENS < 1 || NUM_ALIENS > 8 || COOLDOWN < 1) begin : g_param_err
      $error("alien_bullet_ctrl: parameter out of range");
   end

   logic [NUM_BULLETS-1:0]    free_vec;
   logic [NUM_BULLETS-1:0]    alloc_oh;
   logic [9:0]                spawn_x;
   logic [9:0]                spawn_y;
   logic                      spawn_ok;
   logic                      cool_ok;
   logic                      accept;

   logic [NUM_BULLETS-1:0]    active_nxt;
   logic [NUM_BULLETS*10-1:0] x_nxt;
   logic [NUM_BULLETS*10-1:0] y_nxt;
   logic                      hit_nxt;
   logic [2:0]                sel_nxt;
   logic [9:0]                ny;
   logic [10:0]               bx11;
   logic [10:0]               ny11;
   logic [10:0]               px11;

   // Allocation looks only at the registered active vector, so a slot freed this tick stays unavailable.
   assign free_vec = ~bullet_active;
   assign alloc_oh = free_vec & (~free_vec + NUM_BULLETS'(1));
   assign spawn_x  = shooter_x + 10'(ALIEN_W / 2 - BULLET_W / 2);
   assign spawn_y  = {1'b0, shooter_y} + 10'(ALIEN_H);
   assign spawn_ok = spawn_y < 10'(SCREEN_H);
   assign accept   = alien_shoot && (|free_vec) && spawn_ok && cool_ok;
   assign px11     = {1'b0, player_x};

`ifdef ALIEN_BULLET_COOLDOWN_EN
   localparam int CW = $clog2(COOLDOWN + 1);
   logic [CW-1:0] cool_cnt;

   assign cool_ok = (cool_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cool_cnt <= '0;
      end else if (accept) begin
         cool_cnt <= CW'(COOLDOWN);
      end else if (tick && cool_cnt != '0) begin
         cool_cnt <= cool_cnt - CW'(1);
      end
   end
`else
   assign cool_ok = 1'b1;
`endif

   always_comb begin
      active_nxt = bullet_active;
      x_nxt      = bullet_x;
      y_nxt      = bullet_y;
      hit_nxt    = 1'b0;
      ny         = '0;
      bx11       = '0;
      ny11       = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         ny   = bullet_y[i*10 +: 10] + 10'(SPEED);
         bx11 = {1'b0, bullet_x[i*10 +: 10]};
         ny11 = {1'b0, ny};
         if (tick && bullet_active[i]) begin
            if (ny >= 10'(SCREEN_H)) begin
               active_nxt[i] = 1'b0;
            end else if ((bx11 + 11'(BULLET_W) > px11) &&
                         (bx11 < px11 + 11'(PLAYER_W)) &&
                         (ny11 + 11'(BULLET_H) > 11'(PLAYER_Y)) &&
                         (ny11 < 11'(PLAYER_Y + PLAYER_H))) begin
               active_nxt[i] = 1'b0;
               hit_nxt       = 1'b1;
            end else begin
               y_nxt[i*10 +: 10] = ny;
            end
         end
         // New bullet lands unmoved; it is first hit-tested on the following tick.
         if (accept && alloc_oh[i]) begin
            active_nxt[i]     = 1'b1;
            x_nxt[i*10 +: 10] = spawn_x;
            y_nxt[i*10 +: 10] = spawn_y;
         end
      end
   end

   always_comb begin
      sel_nxt = shooter_sel;
      if (accept) begin
         sel_nxt = (shooter_sel == 3'(NUM_ALIENS - 1)) ? 3'd0 : shooter_sel + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bullet_active <= '0;
         bullet_x      <= '0;
         bullet_y      <= '0;
         shooter_sel   <= '0;
         player_hit    <= 1'b0;
         shot_dropped  <= 1'b0;
      end else begin
         bullet_active <= active_nxt;
         bullet_x      <= x_nxt;
         bullet_y      <= y_nxt;
         shooter_sel   <= sel_nxt;
         player_hit    <= hit_nxt;
         shot_dropped  <= alien_shoot && !accept;
      end
   end

endmodule

// File: tb/tb_alien_bullet_ctrl.sv
// Bench for alien_bullet_ctrl: integer slot model checked every cycle plus directed literal checks.
module tb_alien_bullet_ctrl;
   localparam int NB = 4;
`ifdef ALIEN_BULLET_COOLDOWN_EN
   localparam bit COOL_EN = 1'b1;
`else
   localparam bit COOL_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            tick = 1'b0;
   logic            alien_shoot = 1'b0;
   logic [9:0]      shooter_x = '0;
   logic [8:0]      shooter_y = '0;
   logic [9:0]      player_x = '0;
   logic [2:0]      shooter_sel;
   logic [NB-1:0]   bullet_active;
   logic [NB*10-1:0] bullet_x;
   logic [NB*10-1:0] bullet_y;
   logic            player_hit;
   logic            shot_dropped;

   int checks = 0;
   int failures = 0;

   int m_act[NB];
   int m_x[NB];
   int m_y[NB];
   int m_sel = 0;
   int m_hit = 0;
   int m_drop = 0;
   int m_cool = 0;

   always #5 clk = ~clk;

   alien_bullet_ctrl dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .alien_shoot(alien_shoot),
      .shooter_x(shooter_x), .shooter_y(shooter_y), .player_x(player_x),
      .shooter_sel(shooter_sel), .bullet_active(bullet_active),
      .bullet_x(bullet_x), .bullet_y(bullet_y),
      .player_hit(player_hit), .shot_dropped(shot_dropped)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int slot_x(input int i);
      return int'(bullet_x[i*10 +: 10]);
   endfunction

   function automatic int slot_y(input int i);
      return int'(bullet_y[i*10 +: 10]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NB; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_sel = 0; m_hit = 0; m_drop = 0; m_cool = 0;
   endtask

   // Screen-rule model: integer coordinates, player box overlap tested with plain inequalities.
   task automatic model_step();
      int  free_slot = -1;
      int  sx, sy, ny, px;
      bit  acc;
      int  hit = 0;
      for (int i = 0; i < NB; i++)
         if (m_act[i] == 0 && free_slot < 0) free_slot = i;
      sx  = (int'(shooter_x) + 7) % 1024;
      sy  = int'(shooter_y) + 16;
      px  = int'(player_x);
      acc = alien_shoot && free_slot >= 0 && sy < 480 && (!COOL_EN || m_cool == 0);
      if (tick) begin
         for (int i = 0; i < NB; i++) begin
            if (m_act[i] != 0) begin
               ny = (m_y[i] + 4) % 1024;
               if (ny >= 480) m_act[i] = 0;
               else if (m_x[i] + 2 > px && m_x[i] < px + 24 && ny + 6 > 440 && ny < 452) begin
                  m_act[i] = 0;
                  hit = 1;
               end else m_y[i] = ny;
            end
         end
      end
      if (acc) begin
         m_act[free_slot] = 1;
         m_x[free_slot]   = sx;
         m_y[free_slot]   = sy;
         m_sel = (m_sel + 1) % 5;
      end
      m_hit  = hit;
      m_drop = (alien_shoot && !acc) ? 1 : 0;
      if (COOL_EN) begin
         if (acc) m_cool = 8;
         else if (tick && m_cool > 0) m_cool = m_cool - 1;
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_clear();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NB; i++) begin
            chk($sformatf("model_active[%0d]", i), int'(bullet_active[i]), m_act[i]);
            chk($sformatf("model_x[%0d]", i), slot_x(i), m_x[i]);
            chk($sformatf("model_y[%0d]", i), slot_y(i), m_y[i]);
         end
         chk("model_sel", int'(shooter_sel), m_sel);
         chk("model_hit", int'(player_hit), m_hit);
         chk("model_drop", int'(shot_dropped), m_drop);
      end
   end

   task automatic step(input bit s, input bit t);
      alien_shoot = s;
      tick = t;
      @(posedge clk);
      #1;
      alien_shoot = 1'b0;
      tick = 1'b0;
   endtask

   task automatic do_reset();
      alien_shoot = 1'b0;
      tick = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("reset_active", int'(bullet_active), 0);
      chk("reset_sel", int'(shooter_sel), 0);
      chk("reset_hit", int'(player_hit), 0);
      chk("reset_drop", int'(shot_dropped), 0);

      // Spawn
      shooter_x = 10'd100; shooter_y = 9'd50; player_x = 10'd0;
      step(1, 0);
      chk("spawn_active", int'(bullet_active), 1);
      chk("spawn_x", slot_x(0), 107);
      chk("spawn_y", slot_y(0), 66);
      chk("spawn_sel", int'(shooter_sel), 1);

      // Fall and expire
      do_reset();
      shooter_y = 9'd450;
      step(1, 0);
      chk("fall_spawn_y", slot_y(0), 466);
      step(0, 1);
      chk("fall_y1", slot_y(0), 470);
      step(0, 1);
      chk("fall_y2", slot_y(0), 474);
      chk("fall_alive2", int'(bullet_active), 1);
      step(0, 1);
      chk("fall_y3", slot_y(0), 478);
      step(0, 1);
      chk("fall_freed", int'(bullet_active), 0);
      chk("fall_no_hit", int'(player_hit), 0);
      chk("fall_keep_y", slot_y(0), 478);

      // Hit: bullet 207..208 wide, player box starts at y=440
      do_reset();
      player_x = 10'd200; shooter_x = 10'd200; shooter_y = 9'd410;
      step(1, 0);
      chk("hit_spawn", slot_x(0) * 1000 + slot_y(0), 207426);
      step(0, 1);
      chk("hit_y430", slot_y(0), 430);
      chk("hit_none430", int'(player_hit), 0);
      step(0, 1);
      chk("hit_none434", int'(player_hit), 0);
      step(0, 1);
      chk("hit_pulse", int'(player_hit), 1);
      chk("hit_freed", int'(bullet_active), 0);
      step(0, 0);
      chk("hit_pulse_end", int'(player_hit), 0);

      // Left edge graze: bullet right edge touches player left edge, no overlap
      do_reset();
      player_x = 10'd200; shooter_x = 10'd191; shooter_y = 9'd410;
      step(1, 0);
      repeat (3) step(0, 1);
      chk("edge_alive", int'(bullet_active), 1);
      chk("edge_y", slot_y(0), 438);
      chk("edge_no_hit", int'(player_hit), 0);

`ifndef ALIEN_BULLET_COOLDOWN_EN
      // Full pool
      do_reset();
      player_x = 10'd0; shooter_x = 10'd10; shooter_y = 9'd10;
      repeat (4) step(1, 0);
      chk("pool_active", int'(bullet_active), 15);
      chk("pool_slot3", slot_x(3) * 1000 + slot_y(3), 17026);
      chk("pool_sel4", int'(shooter_sel), 4);
      step(1, 0);
      chk("pool_drop", int'(shot_dropped), 1);
      chk("pool_sel_hold", int'(shooter_sel), 4);
      step(0, 0);
      chk("pool_drop_end", int'(shot_dropped), 0);

      // Request and tick together: old bullet leaves, new one uses the next slot unmoved
      do_reset();
      shooter_x = 10'd100; shooter_y = 9'd463;
      step(1, 0);
      step(1, 1);
      chk("same_active", int'(bullet_active), 2);
      chk("same_y1", slot_y(1), 479);
      step(0, 1);
      chk("same_freed", int'(bullet_active), 0);
`endif

      // Spawn boundary and round-robin wrap
      do_reset();
      player_x = 10'd0; shooter_x = 10'd100; shooter_y = 9'd464;
      step(1, 0);
      chk("spawn480_drop", int'(shot_dropped), 1);
      chk("spawn480_active", int'(bullet_active), 0);
      chk("spawn480_sel", int'(shooter_sel), 0);
      shooter_y = 9'd463;
      for (int k = 0; k < 5; k++) begin
         step(1, 0);
         chk($sformatf("rr_sel%0d", k), int'(shooter_sel), (k + 1) % 5);
         repeat (8) step(0, 1);
      end

`ifdef ALIEN_BULLET_COOLDOWN_EN
      // Cooldown
      do_reset();
      shooter_x = 10'd300; shooter_y = 9'd100;
      step(1, 0);
      chk("cool_first", int'(bullet_active), 1);
      repeat (3) step(0, 1);
      step(1, 0);
      chk("cool_drop3", int'(shot_dropped), 1);
      repeat (4) step(0, 1);
      step(1, 0);
      chk("cool_drop7", int'(shot_dropped), 1);
      chk("cool_still1", int'(bullet_active), 1);
      step(0, 1);
      step(1, 0);
      chk("cool_accept8", int'(shot_dropped), 0);
      chk("cool_active2", int'(bullet_active), 3);
      chk("cool_sel2", int'(shooter_sel), 2);
`endif

      // Reset mid-flight with a pending drop pulse
      do_reset();
      shooter_y = 9'd100;
      step(1, 0);
      shooter_y = 9'd470;
      step(1, 0);
      chk("mid_pre_drop", int'(shot_dropped), 1);
      chk("mid_pre_active", int'(bullet_active), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_active", int'(bullet_active), 0);
      chk("mid_drop", int'(shot_dropped), 0);
      chk("mid_sel", int'(shooter_sel), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
